// File: rtl/datapath_pkg.sv
// datapath_pkg: shared widths and opcode encodings for the lab CPU datapath
package datapath_pkg;
    localparam int DW = 16;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;
endpackage

// File: rtl/datapath_regfile.sv
// regfile: eight 16-bit registers, one sync write port, one combinational read port
module regfile
    import datapath_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          write,
    input  logic [2:0]    writenum,
    input  logic [2:0]    readnum,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out
);
    logic [DW-1:0] R0, R1, R2, R3, R4, R5, R6, R7;
    // write the addressed register; reset clears all of them
    always_ff @(posedge clk) begin
        if (reset) begin
            R0 <= '0;
            R1 <= '0;
            R2 <= '0;
            R3 <= '0;
            R4 <= '0;
            R5 <= '0;
            R6 <= '0;
            R7 <= '0;
        end else if (write) begin
            case (writenum)
                3'd0: R0 <= data_in;
                3'd1: R1 <= data_in;
                3'd2: R2 <= data_in;
                3'd3: R3 <= data_in;
                3'd4: R4 <= data_in;
                3'd5: R5 <= data_in;
                3'd6: R6 <= data_in;
                default: R7 <= data_in;
            endcase
        end
    end
    // unbypassed read: same-cycle write is seen only after the edge
    always_comb begin
        case (readnum)
            3'd0: data_out = R0;
            3'd1: data_out = R1;
            3'd2: data_out = R2;
            3'd3: data_out = R3;
            3'd4: data_out = R4;
            3'd5: data_out = R5;
            3'd6: data_out = R6;
            default: data_out = R7;
        endcase
    end
endmodule

// File: rtl/datapath.sv
// datapath: regfile, A/B operand regs, B-path shifter, 4-op ALU, C result and Z flag
module datapath
    import datapath_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datapath_in,
    input  logic          write,
    input  logic          vsel,
    input  logic [2:0]    writenum,
    input  logic [2:0]    readnum,
    input  logic          loada,
    input  logic          loadb,
    input  logic          asel,
    input  logic          bsel,
    input  logic [1:0]    shift,
    input  logic [1:0]    ALUop,
    input  logic          loadc,
    input  logic          loads,
    output logic [DW-1:0] datapath_out,
    output logic          Z_out
);
    logic [DW-1:0] rd, a, b, c, sh, ain, bin, alu;
    logic          z;

    regfile REGFILE (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .writenum (writenum),
        .readnum  (readnum),
        .data_in  (vsel ? datapath_in : c),
        .data_out (rd)
    );

    // shifter, operand selects and ALU are purely combinational
    always_comb begin
        sh  = shift == SH_LSL ? {b[DW-2:0], 1'b0} :
              shift == SH_LSR ? {1'b0, b[DW-1:1]} :
              shift == SH_ASR ? {b[DW-1], b[DW-1:1]} : b;
        ain = asel ? '0 : a;
        bin = bsel ? {{(DW-5){1'b0}}, datapath_in[4:0]} : sh;
        alu = ALUop == ALU_ADD ? ain + bin :
              ALUop == ALU_SUB ? ain - bin :
              ALUop == ALU_AND ? ain & bin : ~bin;
    end

    // operand, result and status registers, each with its own load strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            a <= '0;
            b <= '0;
            c <= '0;
            z <= 1'b0;
        end else begin
            if (loada) a <= rd;
            if (loadb) b <= rd;
            if (loadc) c <= alu;
            if (loads) z <= (alu == '0);
        end
    end

    assign datapath_out = c;
    assign Z_out        = z;
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed self-checking bench for the lab CPU datapath
module tb_datapath;
    logic        clk = 0;
    logic        reset, write, vsel, loada, loadb, asel, bsel, loadc, loads;
    logic [15:0] datapath_in, datapath_out;
    logic [2:0]  writenum, readnum;
    logic [1:0]  shift, ALUop;
    logic        Z_out;
    int          n_checks = 0;
    int          n_fail = 0;

    datapath dut (
        .clk(clk), .reset(reset), .datapath_in(datapath_in), .write(write), .vsel(vsel),
        .writenum(writenum), .readnum(readnum), .loada(loada), .loadb(loadb),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop), .loadc(loadc),
        .loads(loads), .datapath_out(datapath_out), .Z_out(Z_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] get_r(input int n);
        case (n)
            0: return dut.REGFILE.R0;
            1: return dut.REGFILE.R1;
            2: return dut.REGFILE.R2;
            3: return dut.REGFILE.R3;
            4: return dut.REGFILE.R4;
            5: return dut.REGFILE.R5;
            6: return dut.REGFILE.R6;
            default: return dut.REGFILE.R7;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; write = 0; vsel = 0; loada = 0; loadb = 0; asel = 0; bsel = 0;
        loadc = 0; loads = 0; shift = 2'b00; ALUop = 2'b00;
        writenum = 0; readnum = 0; datapath_in = 0;
    endtask

    task automatic wr(input logic [2:0] n, input logic [15:0] v);
        idle(); write = 1; vsel = 1; writenum = n; datapath_in = v;
        tick(); idle();
    endtask

    task automatic ld(input logic [2:0] n, input logic la, input logic lb);
        idle(); readnum = n; loada = la; loadb = lb;
        tick(); idle();
    endtask

    task automatic op(input logic [1:0] s, input logic [1:0] f, input logic ls);
        idle(); shift = s; ALUop = f; loadc = 1; loads = ls;
        tick(); idle();
    endtask

    task automatic wb(input logic [2:0] n);
        idle(); write = 1; vsel = 0; writenum = n;
        tick(); idle();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) wr(3'(i), 16'h1111 * 16'(i + 1));
        idle(); asel = 1; bsel = 1; loadc = 1; loads = 1; tick();
        idle(); asel = 1; bsel = 1; datapath_in = 16'h0005; loadc = 1; tick();
        n_checks++;
        if (datapath_out !== 16'h0005 || Z_out !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: out=%h Z=%b expected 0005 1", datapath_out, Z_out);
        end
        idle(); reset = 1; write = 1; vsel = 1; datapath_in = 16'hABCD; loada = 1; loadb = 1;
        loadc = 1; loads = 1; bsel = 1; tick(); idle();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (get_r(i) !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_R%0d: got %h expected 0000", i, get_r(i));
            end
        end
        n_checks++;
        if (datapath_out !== 16'h0000 || Z_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: out=%h Z=%b expected 0000 0", datapath_out, Z_out);
        end
    endtask

    task automatic test_add_shift();
        wr(0, 16'd7); wr(1, 16'd2);
        ld(1, 1, 0); ld(0, 0, 1);
        op(2'b01, 2'b00, 0);
        n_checks++;
        if (datapath_out !== 16'd16) begin
            n_fail++;
            $display("FAIL add_lsl_out: got %0d expected 16", datapath_out);
        end
        wb(2);
        n_checks++;
        if (dut.REGFILE.R2 !== 16'd16) begin
            n_fail++;
            $display("FAIL add_lsl_R2: got %0d expected 16", dut.REGFILE.R2);
        end
    endtask

    task automatic test_sub_shift();
        wr(0, 16'd13); wr(1, 16'd7);
        ld(0, 1, 0); ld(1, 0, 1);
        op(2'b10, 2'b01, 0);
        wb(2);
        n_checks++;
        if (dut.REGFILE.R2 !== 16'd10) begin
            n_fail++;
            $display("FAIL sub_lsr_R2: got %0d expected 10", dut.REGFILE.R2);
        end
    endtask

    task automatic test_and_not_asr();
        wr(4, 16'hFFFF); wr(5, 16'h8004);
        ld(4, 1, 0); ld(5, 0, 1);
        op(2'b11, 2'b10, 0);
        n_checks++;
        if (datapath_out !== 16'hC002) begin
            n_fail++;
            $display("FAIL and_asr: got %h expected C002", datapath_out);
        end
        op(2'b11, 2'b11, 0);
        n_checks++;
        if (datapath_out !== 16'h3FFD) begin
            n_fail++;
            $display("FAIL not_asr: got %h expected 3FFD", datapath_out);
        end
        op(2'b01, 2'b10, 0);
        n_checks++;
        if (datapath_out !== 16'h0008) begin
            n_fail++;
            $display("FAIL and_lsl_msb: got %h expected 0008", datapath_out);
        end
        op(2'b10, 2'b00, 0);
        n_checks++;
        if (datapath_out !== 16'h4001) begin
            n_fail++;
            $display("FAIL add_lsr_wrap: got %h expected 4001", datapath_out);
        end
    endtask

    task automatic test_status();
        wr(6, 16'd5);
        ld(6, 1, 1);
        op(2'b00, 2'b01, 1);
        n_checks++;
        if (Z_out !== 1'b1 || datapath_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL z_set: Z=%b out=%h expected 1 0000", Z_out, datapath_out);
        end
        op(2'b00, 2'b00, 0);
        n_checks++;
        if (Z_out !== 1'b1 || datapath_out !== 16'd10) begin
            n_fail++;
            $display("FAIL z_hold: Z=%b out=%h expected 1 000a", Z_out, datapath_out);
        end
        idle(); loads = 1; tick(); idle();
        n_checks++;
        if (Z_out !== 1'b0 || datapath_out !== 16'd10) begin
            n_fail++;
            $display("FAIL z_clear_only: Z=%b out=%h expected 0 000a", Z_out, datapath_out);
        end
    endtask

    task automatic test_selects();
        idle(); asel = 1; bsel = 1; datapath_in = 16'hFFF3; loadc = 1; tick(); idle();
        n_checks++;
        if (datapath_out !== 16'd19) begin
            n_fail++;
            $display("FAIL imm_add: got %h expected 0013", datapath_out);
        end
        idle(); asel = 1; ALUop = 2'b01; loadc = 1; tick(); idle();
        n_checks++;
        if (datapath_out !== 16'hFFFB) begin
            n_fail++;
            $display("FAIL zero_minus_b: got %h expected FFFB", datapath_out);
        end
    endtask

    task automatic test_collision();
        wr(3, 16'd4);
        idle(); write = 1; vsel = 1; writenum = 3; datapath_in = 16'd9; readnum = 3; loada = 1;
        tick(); idle();
        n_checks++;
        if (dut.REGFILE.R3 !== 16'd9) begin
            n_fail++;
            $display("FAIL collide_R3: got %0d expected 9", dut.REGFILE.R3);
        end
        idle(); bsel = 1; loadc = 1; tick(); idle();
        n_checks++;
        if (datapath_out !== 16'd4) begin
            n_fail++;
            $display("FAIL collide_A: got %0d expected 4", datapath_out);
        end
    endtask

    task automatic test_back_to_back();
        ld(6, 0, 1);
        idle(); ALUop = 2'b11; loadc = 1; write = 1; vsel = 0; writenum = 7; tick(); idle();
        n_checks++;
        if (dut.REGFILE.R7 !== 16'd4 || datapath_out !== 16'hFFFA) begin
            n_fail++;
            $display("FAIL b2b: R7=%h out=%h expected 0004 FFFA", dut.REGFILE.R7, datapath_out);
        end
    endtask

    initial begin
        idle(); reset = 1;
        tick(); tick();
        idle();
        test_reset();
        test_add_shift();
        test_sub_shift();
        test_and_not_asr();
        test_status();
        test_selects();
        test_collision();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
